reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter SP_IDX, default 29: index of the stack-pointer register.
REQ-004 SHALL have parameter SP_RESET, default 32'h7FFF_EFFC: reset value of register SP_IDX.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port Reg_Write_i  input  1  write enable.
REQ-009 SHALL have port Write_Register_i  input  ADDR_W  write address.
REQ-010 SHALL have port Write_Data_i  input  DATA_W  write data.
REQ-011 SHALL have port Read_Register_1_i  input  ADDR_W  read port 1 address.
REQ-012 SHALL have port Read_Register_2_i  input  ADDR_W  read port 2 address.
REQ-013 SHALL have port Read_Data_1_o  output  DATA_W  read port 1 data.
REQ-014 SHALL have port Read_Data_2_o  output  DATA_W  read port 2 data.
REQ-015 SHALL have port Issue_Valid_i  input  1  an instruction writing Issue_Dest_i is issued this cycle.
REQ-016 SHALL have port Issue_Dest_i  input  ADDR_W  destination of issued instruction.
REQ-017 SHALL have port Flush_i  input  1  synchronous clear of all pending flags.
REQ-018 SHALL have port Busy_1_o  output  1  port 1 operand not yet available.
REQ-019 SHALL have port Busy_2_o  output  1  port 2 operand not yet available.

Function
REQ-020 SHALL write Write_Data_i to register Write_Register_i on rising clk when Reg_Write_i=1 and Write_Register_i!=0; write visible in stored state next cycle.
REQ-021 SHALL treat register 0 as constant zero: reads return 0, writes ignored, never pending, never busy.
REQ-022 SHALL provide reads combinationally (zero-cycle latency) from the addressed register.
REQ-023 SHALL, when BYPASS=1, drive Read_Data_n_o = Write_Data_i if Reg_Write_i=1 and Write_Register_i = Read_Register_n_i != 0; both ports independently.
REQ-024 SHALL, when BYPASS=0, return the pre-write stored value in the write cycle.
REQ-025 SHALL keep one pending bit per register (scoreboard); bit 0 hardwired 0.
REQ-026 SHALL set pending[Issue_Dest_i] on rising clk when Issue_Valid_i=1 and Issue_Dest_i!=0.
REQ-027 SHALL clear pending[Write_Register_i] on rising clk when Reg_Write_i=1 and Write_Register_i!=0.
REQ-028 SHALL, on simultaneous set and clear of the same bit, leave it set (new producer wins).
REQ-029 SHALL, when Flush_i=1, clear all pending bits except one being set by Issue_Valid_i in the same cycle.
REQ-030 SHALL drive Busy_n_o = pending[Read_Register_n_i], masked to 0 when BYPASS=1 and a write to the same nonzero address occurs in that cycle.
REQ-031 SHALL allow both read ports to address the same register, each receiving identical data/busy.
REQ-032 SHALL produce no X on outputs for any in-range address; all 2**ADDR_W entries implemented.

Reset
REQ-033 SHALL, while reset=0, asynchronously force all registers to 0 except register SP_IDX = SP_RESET, and all pending bits to 0.
REQ-034 SHALL ignore writes, issues and flush while reset=0; first update occurs on first rising clk after reset=1.
REQ-035 SHALL, on reset asserted mid-operation, discard in-flight write and issue of that cycle.

Verification
REQ-036 Reset: assert reset=0 -> register 29 reads 32'h7FFF_EFFC, all others 0, Busy_1_o=Busy_2_o=0.
REQ-037 Write/read: write 32'hDEAD_BEEF to r5, next cycle read r5 on both ports -> both 32'hDEAD_BEEF; write 32'h1234 to r0 -> r0 reads 0.
REQ-038 Bypass: same cycle write 32'hA5A5_A5A5 to r7 and read r7 on port 1 -> Read_Data_1_o=32'hA5A5_A5A5 (BYPASS=1), old value (BYPASS=0).
REQ-039 Scoreboard: issue r9, read r9 -> Busy_1_o=1 next cycle; write r9 with 32'h42 -> Busy masked that cycle, 0 after; concurrent issue+write r9 -> stays busy.
REQ-040 Flush: issue r3, r4 in successive cycles, then Flush_i with issue r6 -> r3,r4 not busy, r6 busy.
REQ-041 Async reset mid-write: reset=0 between clk edges while writing r12 -> r12=0, all pending clear immediately.

Source files
------------

// File: rtl/reg_file_sb.sv
// Purpose : 2**ADDR_W x DATA_W register file, 2 read / 1 write ports, with a per-register pending-write scoreboard.
// Latency : reads and busy flags are combinational; writes, issues and flush take effect on the next rising clk.
// Backpressure: none; every write/issue is accepted, and Busy_n_o tells the issue stage that an operand is not ready.
//
// Ports:
//   clk, reset (async, active-low)
//   Reg_Write_i / Write_Register_i / Write_Data_i       : write port; clears the pending bit of its target
//   Read_Register_n_i -> Read_Data_n_o, Busy_n_o         : read ports n = 1, 2
//   Issue_Valid_i / Issue_Dest_i                         : marks a destination as pending
//   Flush_i                                              : drops every pending bit except a same-cycle issue
module reg_file_sb #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                SP_IDX   = 29,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h7FFF_EFFC,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Reg_Write_i,
    input  logic [ADDR_W-1:0] Write_Register_i,
    input  logic [DATA_W-1:0] Write_Data_i,
    input  logic [ADDR_W-1:0] Read_Register_1_i,
    input  logic [ADDR_W-1:0] Read_Register_2_i,
    output logic [DATA_W-1:0] Read_Data_1_o,
    output logic [DATA_W-1:0] Read_Data_2_o,
    input  logic              Issue_Valid_i,
    input  logic [ADDR_W-1:0] Issue_Dest_i,
    input  logic              Flush_i,
    output logic              Busy_1_o,
    output logic              Busy_2_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;

    // Writes and issues to r0 are treated as if they never happened.
    logic wr_en;
    logic iss_en;
    assign wr_en  = Reg_Write_i   && (Write_Register_i != '0);
    assign iss_en = Issue_Valid_i && (Issue_Dest_i     != '0);

    // Register array. r0 is reset to zero and has no write path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[Write_Register_i] <= Write_Data_i;
        end
    end

    // Scoreboard next state: flush and write-clear first, then the issue set,
    // so a new producer always wins over a retiring one or a flush.
    always_comb begin
        pending_nxt = Flush_i ? '0 : pending;
        if (wr_en) begin
            pending_nxt[Write_Register_i] = 1'b0;
        end
        if (iss_en) begin
            pending_nxt[Issue_Dest_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Forwarding hit: the write in flight this cycle targets this read address.
    // wr_en already excludes r0, so a hit never happens on r0.
    logic fwd_1;
    logic fwd_2;
    assign fwd_1 = BYPASS && wr_en && (Write_Register_i == Read_Register_1_i);
    assign fwd_2 = BYPASS && wr_en && (Write_Register_i == Read_Register_2_i);

    always_comb begin
        Read_Data_1_o = '0;
        if (Read_Register_1_i != '0) begin
            Read_Data_1_o = fwd_1 ? Write_Data_i : regs[Read_Register_1_i];
        end
    end

    always_comb begin
        Read_Data_2_o = '0;
        if (Read_Register_2_i != '0) begin
            Read_Data_2_o = fwd_2 ? Write_Data_i : regs[Read_Register_2_i];
        end
    end

    // The operand being written this cycle is forwarded, so it is not busy.
    assign Busy_1_o = pending[Read_Register_1_i] && !fwd_1;
    assign Busy_2_o = pending[Read_Register_2_i] && !fwd_2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with forwarding, one without, sharing all inputs.
// A behavioural model (array of values + array of pending flags) is compared on every negedge,
// and a few directed scenarios are pinned with literal expectations.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 32;
    localparam logic [DW-1:0] SP_VAL = 32'h7FFF_EFFC;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          iv;
    logic [AW-1:0] dest;
    logic          flush;

    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          busy1_b, busy2_b, busy1_n, busy2_n;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    logic [DW-1:0] m_reg [D];
    bit            m_pend [D];

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .reset(reset),
        .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
        .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
        .Read_Data_1_o(rd1_b), .Read_Data_2_o(rd2_b),
        .Issue_Valid_i(iv), .Issue_Dest_i(dest), .Flush_i(flush),
        .Busy_1_o(busy1_b), .Busy_2_o(busy2_b)
    );

    reg_file_sb #(.BYPASS(1'b0)) u_dut_nobyp (
        .clk(clk), .reset(reset),
        .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
        .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
        .Read_Data_1_o(rd1_n), .Read_Data_2_o(rd2_n),
        .Issue_Valid_i(iv), .Issue_Dest_i(dest), .Flush_i(flush),
        .Busy_1_o(busy1_n), .Busy_2_o(busy2_n)
    );

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_reg[i]  = (i == 29) ? SP_VAL : '0;
            m_pend[i] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            if (flush) begin
                for (int i = 0; i < D; i++) m_pend[i] = 1'b0;
            end
            if (we && wa != 0) begin
                m_reg[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (iv && dest != 0) m_pend[dest] = 1'b1;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we && wa == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every negedge, both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("rd1_byp",   rd1_b,          exp_rd(ra1, 1'b1));
            cmp("rd2_byp",   rd2_b,          exp_rd(ra2, 1'b1));
            cmp("busy1_byp", {31'd0, busy1_b}, {31'd0, exp_busy(ra1, 1'b1)});
            cmp("busy2_byp", {31'd0, busy2_b}, {31'd0, exp_busy(ra2, 1'b1)});
            cmp("rd1_nobyp", rd1_n,          exp_rd(ra1, 1'b0));
            cmp("rd2_nobyp", rd2_n,          exp_rd(ra2, 1'b0));
            cmp("busy1_nobyp", {31'd0, busy1_n}, {31'd0, exp_busy(ra1, 1'b0)});
            cmp("busy2_nobyp", {31'd0, busy2_n}, {31'd0, exp_busy(ra2, 1'b0)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        iv = 1'b0; dest = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, D - 1));
    endfunction

    initial begin
        idle();
        model_reset();
        check_en = 1'b1;

        // Reset state: sweep every address on both ports while held in reset.
        for (int a = 0; a < D; a++) begin
            ra1 = AW'(a);
            ra2 = AW'(D - 1 - a);
            we = 1'b1; wa = AW'(a); wd = 32'hFFFF_FFFF;  // ignored during reset
            iv = 1'b1; dest = AW'(a);
            at_neg();
        end
        idle();
        ra1 = 5'd29; ra2 = 5'd5;
        at_neg();
        cmp("lit_reset_sp",   rd1_b, SP_VAL);
        cmp("lit_reset_r5",   rd2_b, 32'h0);
        cmp("lit_reset_busy", {30'd0, busy1_b, busy2_b}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Write r5, read it back on both ports.
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        tick();
        idle();
        ra1 = 5'd5; ra2 = 5'd5;
        at_neg();
        cmp("lit_r5_p1", rd1_b, 32'hDEAD_BEEF);
        cmp("lit_r5_p2", rd2_b, 32'hDEAD_BEEF);
        tick();

        // Write to r0 is dropped.
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        tick();
        idle();
        at_neg();
        cmp("lit_r0_zero", rd1_b, 32'h0);
        tick();

        // Same-cycle write/read of r7.
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; ra1 = 5'd7;
        at_neg();
        cmp("lit_bypass_on",  rd1_b, 32'hA5A5_A5A5);
        cmp("lit_bypass_off", rd1_n, 32'h0);
        tick();
        idle();

        // Scoreboard on r9.
        iv = 1'b1; dest = 5'd9;
        tick();
        idle();
        ra1 = 5'd9;
        at_neg();
        cmp("lit_busy_after_issue", {31'd0, busy1_b}, 32'd1);
        tick();
        we = 1'b1; wa = 5'd9; wd = 32'h42; ra1 = 5'd9;
        at_neg();
        cmp("lit_busy_masked",     {31'd0, busy1_b}, 32'd0);
        cmp("lit_busy_unmasked",   {31'd0, busy1_n}, 32'd1);
        tick();
        we = 1'b0;
        at_neg();
        cmp("lit_busy_after_write", {31'd0, busy1_b}, 32'd0);
        cmp("lit_r9_value",         rd1_b, 32'h42);
        tick();
        iv = 1'b1; dest = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h43;
        tick();
        idle();
        ra1 = 5'd9;
        at_neg();
        cmp("lit_issue_wins", {31'd0, busy1_b}, 32'd1);
        tick();

        // Flush with a concurrent issue.
        iv = 1'b1; dest = 5'd3;
        tick();
        dest = 5'd4;
        tick();
        dest = 5'd6; flush = 1'b1;
        tick();
        idle();
        ra1 = 5'd3; ra2 = 5'd4;
        at_neg();
        cmp("lit_flush_r3_r4", {30'd0, busy1_b, busy2_b}, 32'd0);
        tick();
        ra1 = 5'd6; ra2 = 5'd9;
        at_neg();
        cmp("lit_flush_r6", {31'd0, busy1_b}, 32'd1);
        cmp("lit_flush_r9", {31'd0, busy2_b}, 32'd0);
        tick();

        // Async reset in the middle of a write to r12 with r14 pending.
        iv = 1'b1; dest = 5'd14;
        tick();
        idle();
        we = 1'b1; wa = 5'd12; wd = 32'hCAFE_F00D; ra1 = 5'd12; ra2 = 5'd14;
        #1 reset = 1'b0;
        #1;
        cmp("lit_arst_busy_clear", {31'd0, busy2_b}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        we = 1'b0;
        at_neg();
        cmp("lit_arst_r12", rd1_b, 32'h0);
        cmp("lit_arst_sp",  exp_rd(5'd29, 1'b1), SP_VAL);
        tick();

        // Randomized traffic with occasional flushes and mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            we    = 1'($urandom_range(0, 1));
            wa    = pick();
            wd    = $urandom;
            ra1   = pick();
            ra2   = ($urandom_range(0, 7) == 0) ? ra1 : pick();
            iv    = 1'($urandom_range(0, 1));
            dest  = pick();
            flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
            end else begin
                tick();
            end
        end

        idle();
        at_neg();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
